// File: rtl/hub75_pkg.sv
// Shared types and helpers for the HUB75 panel-side receiver.
package hub75_pkg;

    localparam int unsigned RGB_R = 0;
    localparam int unsigned RGB_G = 1;
    localparam int unsigned RGB_B = 2;

    typedef enum logic {
        IDLE = 1'b0,
        DUMP = 1'b1
    } dump_state_t;

    function automatic int unsigned addr_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic int unsigned col_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/hub75_edge_sync.sv
// Registers one interface pin and flags its rising edge against the
// previous registered value.
module hub75_edge_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q,
    output logic rise
);

    logic q_prev;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q      <= 1'b0;
            q_prev <= 1'b0;
        end else begin
            q      <= d;
            q_prev <= q;
        end
    end

    assign rise = q & ~q_prev;

endmodule

// File: rtl/hub75_receiver.sv
// HUB75 panel model: shifts rows in on oclk, latches on lat, streams the
// latched row as (row, column, rgb) words. HUB75_RECEIVER_ONTIME_EN adds oe on-time stats.
module hub75_receiver
    import hub75_pkg::*;
#(
    parameter int unsigned segments   = 1,
    parameter int unsigned rows       = 8,
    parameter int unsigned columns    = 32,
    parameter int unsigned cyclewidth = 16,
    localparam int unsigned AW = addr_width(rows),
    localparam int unsigned CW = col_width(columns),
    localparam int unsigned DW = 3 * segments
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [AW-1:0]         row,
    input  logic [DW-1:0]         rgb,
    input  logic                  oclk,
    input  logic                  lat,
    input  logic                  oe,
    output logic                  wr_valid,
    output logic [AW-1:0]         wr_row,
    output logic [CW-1:0]         wr_column,
    output logic [DW-1:0]         wr_rgb,
    output logic                  row_done,
    output logic                  err_shift,
    output logic                  err_overrun,
    output logic                  stat_valid,
    output logic [AW-1:0]         stat_row,
    output logic [cyclewidth-1:0] stat_oe_cycles
);

    localparam logic [CW:0]   N_COLS   = (CW+1)'(columns);
    localparam logic [CW-1:0] LAST_COL = CW'(columns - 1);

    logic [AW-1:0] s_row;
    logic [DW-1:0] s_rgb;
    logic          s_oe;
    logic          oclk_rise;
    logic          lat_rise;
    logic          oclk_level_unused;
    logic          lat_level_unused;
    logic          oe_rise_unused;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s_row <= '0;
            s_rgb <= '0;
        end else begin
            s_row <= row;
            s_rgb <= rgb;
        end
    end

    hub75_edge_sync u_oclk_sync (
        .clk  (clk),
        .rst_n(rst_n),
        .d    (oclk),
        .q    (oclk_level_unused),
        .rise (oclk_rise)
    );

    hub75_edge_sync u_lat_sync (
        .clk  (clk),
        .rst_n(rst_n),
        .d    (lat),
        .q    (lat_level_unused),
        .rise (lat_rise)
    );

    hub75_edge_sync u_oe_sync (
        .clk  (clk),
        .rst_n(rst_n),
        .d    (oe),
        .q    (s_oe),
        .rise (oe_rise_unused)
    );

    logic [DW-1:0] shift_buf [columns];
    logic [DW-1:0] latch_buf [columns];
    logic [CW:0]   shift_cnt;
    logic [CW:0]   shift_total;
    logic          shift_take;
    logic [AW-1:0] lat_row;

    assign shift_take  = oclk_rise && (shift_cnt != N_COLS);
    assign shift_total = shift_cnt + (CW+1)'(shift_take);

    // A shift coinciding with a latch is forwarded straight into the latch
    // buffer so it counts toward the row being latched.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shift_buf <= '{default: '0};
            latch_buf <= '{default: '0};
            shift_cnt <= '0;
            lat_row   <= '0;
            err_shift <= 1'b0;
        end else begin
            if (shift_take) begin
                shift_buf[shift_cnt[CW-1:0]] <= s_rgb;
            end
            if (lat_rise) begin
                for (int unsigned i = 0; i < columns; i++) begin
                    latch_buf[i] <= (shift_take && shift_cnt == (CW+1)'(i)) ? s_rgb : shift_buf[i];
                end
                lat_row   <= s_row;
                shift_cnt <= '0;
                if (shift_total != N_COLS) begin
                    err_shift <= 1'b1;
                end
            end else if (shift_take) begin
                shift_cnt <= shift_total;
            end
        end
    end

    dump_state_t   state;
    dump_state_t   state_next;
    logic [CW-1:0] col;
    logic [CW-1:0] col_next;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            col   <= '0;
        end else begin
            state <= state_next;
            col   <= col_next;
        end
    end

    always_comb begin
        state_next = state;
        col_next   = col;
        unique case (state)
            IDLE: begin
                if (lat_rise) begin
                    state_next = DUMP;
                    col_next   = '0;
                end
            end
            DUMP: begin
                if (lat_rise) begin
                    col_next = '0;
                end else if (col == LAST_COL) begin
                    state_next = IDLE;
                    col_next   = '0;
                end else begin
                    col_next = col + 1'b1;
                end
            end
            default: begin
                state_next = IDLE;
                col_next   = '0;
            end
        endcase
    end

    always_comb begin
        wr_valid  = 1'b0;
        wr_row    = '0;
        wr_column = '0;
        wr_rgb    = '0;
        row_done  = 1'b0;
        if (state == DUMP) begin
            wr_valid  = 1'b1;
            wr_row    = lat_row;
            wr_column = col;
            wr_rgb    = latch_buf[col];
            // An abandoned dump never reports completion.
            row_done  = (col == LAST_COL) && !lat_rise;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_overrun <= 1'b0;
        end else if (lat_rise && state == DUMP) begin
            err_overrun <= 1'b1;
        end
    end

`ifdef HUB75_RECEIVER_ONTIME_EN
    localparam logic [cyclewidth-1:0] OE_MAX = '1;

    logic [cyclewidth-1:0] oe_cnt;

    // The cycle carrying the latch edge belongs to the new latch period.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            oe_cnt         <= '0;
            stat_valid     <= 1'b0;
            stat_row       <= '0;
            stat_oe_cycles <= '0;
        end else begin
            stat_valid <= lat_rise;
            if (lat_rise) begin
                stat_row       <= lat_row;
                stat_oe_cycles <= oe_cnt;
                oe_cnt         <= cyclewidth'(s_oe);
            end else if (s_oe && oe_cnt != OE_MAX) begin
                oe_cnt <= oe_cnt + 1'b1;
            end
        end
    end
`else
    logic oe_level_unused;

    assign oe_level_unused = s_oe;
    assign stat_valid      = 1'b0;
    assign stat_row        = '0;
    assign stat_oe_cycles  = '0;
`endif

endmodule

// File: tb/tb_hub75_receiver.sv
// Bench for hub75_receiver: table of row transactions with randomized pixel
// data, checked against a column-array scoreboard, plus multi-cycle corner sequences.
module tb_hub75_receiver;

    localparam int unsigned COLS = 32;

    typedef logic [10:0] word_t;

    typedef struct {
        logic [2:0] r;
        int         n;
        int         mode;
        bit         merge;
        bit         exp_err;
    } row_vec_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic [2:0]  row = '0;
    logic [2:0]  rgb = '0;
    logic        oclk = 1'b0;
    logic        lat = 1'b0;
    logic        oe = 1'b0;
    logic        wr_valid;
    logic [2:0]  wr_row;
    logic [4:0]  wr_column;
    logic [2:0]  wr_rgb;
    logic        row_done;
    logic        err_shift;
    logic        err_overrun;
    logic        stat_valid;
    logic [2:0]  stat_row;
    logic [15:0] stat_oe_cycles;

    hub75_receiver #(
        .segments  (1),
        .rows      (8),
        .columns   (32),
        .cyclewidth(16)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .row           (row),
        .rgb           (rgb),
        .oclk          (oclk),
        .lat           (lat),
        .oe            (oe),
        .wr_valid      (wr_valid),
        .wr_row        (wr_row),
        .wr_column     (wr_column),
        .wr_rgb        (wr_rgb),
        .row_done      (row_done),
        .err_shift     (err_shift),
        .err_overrun   (err_overrun),
        .stat_valid    (stat_valid),
        .stat_row      (stat_row),
        .stat_oe_cycles(stat_oe_cycles)
    );

    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc++;

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Monitor: collects streamed words and strobes at the falling edge.
    word_t       obs_q[$];
    int          done_cnt = 0;
    logic [4:0]  done_col = '0;
    int unsigned start_cyc = 0;
    bit          prev_v = 1'b0;
    logic [7:0]  rows_seen = '0;
    int          stat_cnt = 0;
    logic [2:0]  last_stat_row = '0;
    logic [15:0] last_stat_cyc = '0;
    int          stat_nz = 0;

    always @(negedge clk) begin
        if (rst_n) begin
            if (wr_valid) begin
                obs_q.push_back({wr_row, wr_column, wr_rgb});
                rows_seen[wr_row] = 1'b1;
                if (!prev_v) start_cyc = cyc;
            end
            prev_v = wr_valid;
            if (row_done) begin
                done_cnt++;
                done_col = wr_column;
            end
            if (stat_valid) begin
                stat_cnt++;
                last_stat_row = stat_row;
                last_stat_cyc = stat_oe_cycles;
            end
            if (stat_valid || stat_row != 0 || stat_oe_cycles != 0) stat_nz++;
        end else begin
            prev_v = 1'b0;
        end
    end

    // Reference model: the panel's column array, written in shift order.
    logic [2:0]  m_shift [COLS];
    int          m_cnt = 0;
    bit          m_err_shift = 1'b0;
    word_t       exp_q[$];
    int unsigned lat_cyc = 0;

    task automatic model_reset();
        for (int i = 0; i < COLS; i++) m_shift[i] = '0;
        m_cnt = 0;
        m_err_shift = 1'b0;
        exp_q.delete();
        obs_q.delete();
        done_cnt = 0;
    endtask

    task automatic model_shift(input logic [2:0] v);
        if (m_cnt < COLS) begin
            m_shift[m_cnt] = v;
            m_cnt++;
        end
    endtask

    task automatic model_latch(input logic [2:0] r);
        if (m_cnt != COLS) m_err_shift = 1'b1;
        for (int i = 0; i < COLS; i++) exp_q.push_back({r, 5'(i), m_shift[i]});
        m_cnt = 0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        oclk = 1'b0;
        lat = 1'b0;
        oe = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        model_reset();
    endtask

    task automatic shift_one(input logic [2:0] v);
        rgb = v;
        oclk = 1'b1;
        model_shift(v);
        tick();
        oclk = 1'b0;
        tick();
    endtask

    task automatic send_row(input logic [2:0] r, input int n, input int mode, input bit merge);
        for (int c = 0; c < n; c++) begin
            logic [2:0] v;
            case (mode)
                0:       v = (c % 2 == 0) ? 3'b101 : 3'b010;
                1:       v = 3'b111;
                default: v = 3'($urandom);
            endcase
            rgb = v;
            oclk = 1'b1;
            model_shift(v);
            if (merge && c == n - 1) begin
                row = r;
                lat = 1'b1;
                lat_cyc = cyc;
            end
            tick();
            oclk = 1'b0;
            lat = 1'b0;
            repeat ($urandom_range(0, 2)) begin
                rgb = 3'($urandom);
                tick();
            end
            tick();
        end
        if (!merge) begin
            row = r;
            lat = 1'b1;
            lat_cyc = cyc;
            tick();
            lat = 1'b0;
            tick();
        end
        model_latch(r);
    endtask

    task automatic expect_dump(input string tag, input bit chk_latency);
        int guard = 0;
        while (obs_q.size() < exp_q.size() && guard < 200) begin
            tick();
            guard++;
        end
        repeat (3) tick();
        check({tag, "_count"}, obs_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++)
            check($sformatf("%s_w%0d", tag, i), obs_q[i], exp_q[i]);
        check({tag, "_row_done_cnt"}, done_cnt, 1);
        check({tag, "_row_done_col"}, done_col, COLS - 1);
        if (chk_latency) check({tag, "_latency"}, start_cyc - lat_cyc, 2);
        obs_q.delete();
        exp_q.delete();
        done_cnt = 0;
    endtask

    row_vec_t tbl [6];

    initial begin
        bit found;

        tbl[0] = '{3'd5, 32, 0, 1'b0, 1'b0};
        tbl[1] = '{3'd2, 32, 2, 1'b0, 1'b0};
        tbl[2] = '{3'd7, 31, 2, 1'b0, 1'b1};
        tbl[3] = '{3'd0, 32, 1, 1'b0, 1'b1};
        tbl[4] = '{3'd3, 33, 2, 1'b0, 1'b1};
        tbl[5] = '{3'd1, 32, 2, 1'b1, 1'b1};

        #2;
        do_reset();
        check("reset_wr_valid", wr_valid, 0);
        check("reset_row_done", row_done, 0);
        check("reset_err_shift", err_shift, 0);
        check("reset_err_overrun", err_overrun, 0);
        check("reset_stat_valid", stat_valid, 0);

        foreach (tbl[k]) begin
            send_row(tbl[k].r, tbl[k].n, tbl[k].mode, tbl[k].merge);
            expect_dump($sformatf("row%0d", k), 1'b1);
            check($sformatf("row%0d_err_shift", k), err_shift, tbl[k].exp_err);
            check($sformatf("row%0d_err_overrun", k), err_overrun, 0);
        end

        // Second latch ten cycles into a dump restarts it with fresh data.
        do_reset();
        send_row(3'd4, 32, 2, 1'b0);
        while (exp_q.size() > 10) void'(exp_q.pop_back());
        for (int i = 0; i < 4; i++) shift_one(3'($urandom));
        while (cyc < lat_cyc + 10) tick();
        row = 3'd1;
        lat = 1'b1;
        tick();
        lat = 1'b0;
        tick();
        model_latch(3'd1);
        expect_dump("overrun", 1'b0);
        check("overrun_flag", err_overrun, 1);
        check("overrun_err_shift", err_shift, m_err_shift);

        send_row(3'd6, 32, 2, 1'b0);
        found = 1'b0;
        for (int g = 0; g < 80 && !found; g++) begin
            @(negedge clk);
            if (wr_valid && wr_column == 5'd12) found = 1'b1;
        end
        check("middump_reached", found, 1);
        rst_n = 1'b0;
        #1;
        check("middump_wr_valid", wr_valid, 0);
        check("middump_err_shift", err_shift, 0);
        check("middump_err_overrun", err_overrun, 0);
        tick();
        rst_n = 1'b1;
        tick();
        model_reset();

        rows_seen = '0;
        for (int r = 0; r < 8; r++) begin
            send_row(3'(r), 32, 1, r == 4);
            expect_dump($sformatf("frame_r%0d", r), 1'b1);
        end
        check("frame_rows_seen", rows_seen, 8'hff);
        check("frame_err_shift", err_shift, 0);
        check("frame_err_overrun", err_overrun, 0);

        do_reset();
        stat_cnt = 0;
        row = 3'd3;
        lat = 1'b1;
        tick();
        lat = 1'b0;
        repeat (40) tick();
        oe = 1'b1;
        repeat (100) tick();
        oe = 1'b0;
        repeat (3) tick();
        lat = 1'b1;
        tick();
        lat = 1'b0;
        repeat (5) tick();
`ifdef HUB75_RECEIVER_ONTIME_EN
        check("ontime_pulses", stat_cnt, 2);
        check("ontime_row", last_stat_row, 3);
        check("ontime_cycles", last_stat_cyc, 100);
`else
        check("stat_pulses", stat_cnt, 0);
        check("stat_nonzero", stat_nz, 0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
